pong_sprite_engine: RTL and testbench

- Parametrised multi-object renderer and mover for the Pong VGA path; generalises the single fixed red square to NUM_OBJ rectangular sprites.
- Each sprite is either button-driven (paddle) or autonomous bouncing (ball), with boundary clamping, ball-to-paddle collision and a priority colour overlay.
- Sits between video_sync_generator/address generator (pixel_x, pixel_y, sync) and the VGA colour outputs; moves once per frame-derived tick instead of per free-running clock count.

---
 rtl/pong_sprite_engine.sv | 176 +++++++++++++++++
 tb/tb_pong_sprite_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_sprite_engine.sv
// Moves NUM_OBJ rectangular sprites (paddles or bouncing balls) once per frame-derived tick
// and overlays their colours on the background with one pixel clock of latency.
module pong_sprite_engine #(
  parameter int                         NUM_OBJ   = 2,
  parameter int                         H_RES     = 640,
  parameter int                         V_RES     = 480,
  parameter int                         OBJ_W     = 32,
  parameter int                         OBJ_H     = 32,
  parameter int                         STEP      = 2,
  parameter int                         FRAME_DIV = 1,
  parameter logic [NUM_OBJ-1:0]         MODE_MASK = 2'b10,
  parameter logic [10*NUM_OBJ-1:0]      INIT_X    = {10'd300, 10'd100},
  parameter logic [9*NUM_OBJ-1:0]       INIT_Y    = {9'd200, 9'd100},
  parameter logic [24*NUM_OBJ-1:0]      COLOR     = {24'h00FF00, 24'h0000FF}
) (
  input  logic                    iVGA_CLK,
  input  logic                    reset,
  input  logic                    iVS,
  input  logic                    iBLANK_n,
  input  logic [9:0]              pixel_x,
  input  logic [8:0]              pixel_y,
  input  logic [23:0]             bg_bgr,
  input  logic [4*NUM_OBJ-1:0]    btn_n,
  input  logic                    enable,
  output logic [23:0]             oBGR,
  output logic [NUM_OBJ-1:0]      oHIT,
  output logic [10*NUM_OBJ-1:0]   obj_x,
  output logic [9*NUM_OBJ-1:0]    obj_y,
  output logic                    move_tick,
  output logic                    collide
);

  localparam logic signed [10:0] LP_STEP = 11'(STEP);
  localparam logic signed [10:0] LP_XMAX = 11'(H_RES - OBJ_W);
  localparam logic signed [10:0] LP_YMAX = 11'(V_RES - OBJ_H);
  localparam logic [10:0]        LP_WU   = 11'(OBJ_W);
  localparam logic [10:0]        LP_HU   = 11'(OBJ_H);
  localparam logic [9:0]         LP_WPX  = 10'(OBJ_W);
  localparam logic [8:0]         LP_HPX  = 9'(OBJ_H);
  localparam logic [7:0]         LP_DIV_LAST = 8'(FRAME_DIV - 1);

  logic                r_vs_d1, r_vs_d2;
  logic [7:0]          r_frame_cnt;
  logic                r_move_tick, r_collide;
  logic [9:0]          r_x [NUM_OBJ];
  logic [8:0]          r_y [NUM_OBJ];
  logic [NUM_OBJ-1:0]  r_dx, r_dy;
  logic [23:0]         r_bgr;
  logic [NUM_OBJ-1:0]  r_hit;

  logic                w_frame_evt, w_tick_now, w_collide;
  logic [9:0]          w_nx [NUM_OBJ];
  logic [8:0]          w_ny [NUM_OBJ];
  logic [NUM_OBJ-1:0]  w_ndx, w_ndy;
  logic [NUM_OBJ-1:0]  w_hit;
  logic [23:0]         w_bgr;

  assign w_frame_evt = r_vs_d2 & ~r_vs_d1;
  assign w_tick_now  = w_frame_evt & enable & (r_frame_cnt == LP_DIV_LAST);

  // Next positions use only pre-tick state so every sprite sees the same snapshot.
  always_comb begin : p_move
    logic               w_pad_hit, w_dir, w_wall;
    logic signed [10:0] w_cx, w_cy;
    logic [3:0]         w_press;
    w_collide = 1'b0;
    w_pad_hit = 1'b0;
    w_dir     = 1'b0;
    w_wall    = 1'b0;
    w_cx      = '0;
    w_cy      = '0;
    w_press   = '0;
    w_ndx     = r_dx;
    w_ndy     = r_dy;
    for (int i = 0; i < NUM_OBJ; i++) begin
      w_cx = $signed({1'b0, r_x[i]});
      w_cy = $signed({2'b00, r_y[i]});
      if (MODE_MASK[i]) begin
        w_pad_hit = 1'b0;
        for (int j = 0; j < NUM_OBJ; j++) begin
          if (!MODE_MASK[j] &&
              ({1'b0, r_x[i]} < {1'b0, r_x[j]} + LP_WU) &&
              ({1'b0, r_x[j]} < {1'b0, r_x[i]} + LP_WU) &&
              ({2'b00, r_y[i]} < {2'b00, r_y[j]} + LP_HU) &&
              ({2'b00, r_y[j]} < {2'b00, r_y[i]} + LP_HU))
            w_pad_hit = 1'b1;
        end
        w_collide = w_collide | w_pad_hit;
        w_dir     = r_dx[i] ^ w_pad_hit;
        w_cx      = w_dir ? (w_cx + LP_STEP) : (w_cx - LP_STEP);
        w_wall    = (w_cx < 0) || (w_cx > LP_XMAX);
        // A paddle bounce already reversed dx; a wall on the same tick must not undo it.
        w_ndx[i]  = w_dir ^ (w_wall & ~w_pad_hit);
        w_dir     = r_dy[i];
        w_cy      = w_dir ? (w_cy + LP_STEP) : (w_cy - LP_STEP);
        w_wall    = (w_cy < 0) || (w_cy > LP_YMAX);
        w_ndy[i]  = w_dir ^ w_wall;
      end else begin
        w_press = ~btn_n[4*i +: 4];
        if (w_press[0] && !w_press[1])      w_cy = w_cy - LP_STEP;
        else if (w_press[1] && !w_press[0]) w_cy = w_cy + LP_STEP;
        if (w_press[2] && !w_press[3])      w_cx = w_cx - LP_STEP;
        else if (w_press[3] && !w_press[2]) w_cx = w_cx + LP_STEP;
      end
      if (w_cx < 0)            w_nx[i] = '0;
      else if (w_cx > LP_XMAX) w_nx[i] = 10'(LP_XMAX);
      else                     w_nx[i] = w_cx[9:0];
      if (w_cy < 0)            w_ny[i] = '0;
      else if (w_cy > LP_YMAX) w_ny[i] = 9'(LP_YMAX);
      else                     w_ny[i] = w_cy[8:0];
    end
  end

  // Modulo subtraction rejects pixels left of / above the sprite as large values.
  always_comb begin : p_render
    logic [9:0] w_ox;
    logic [8:0] w_oy;
    w_ox  = '0;
    w_oy  = '0;
    w_hit = '0;
    w_bgr = bg_bgr;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      w_ox     = pixel_x - r_x[i];
      w_oy     = pixel_y - r_y[i];
      w_hit[i] = (w_ox < LP_WPX) && (w_oy < LP_HPX);
      if (w_hit[i]) w_bgr = COLOR[24*i +: 24];
    end
    if (!iBLANK_n) w_bgr = '0;
  end

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      r_vs_d1     <= 1'b1;
      r_vs_d2     <= 1'b1;
      r_frame_cnt <= '0;
      r_move_tick <= 1'b0;
      r_collide   <= 1'b0;
      r_dx        <= '1;
      r_dy        <= '1;
      r_bgr       <= '0;
      r_hit       <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_x[i] <= INIT_X[10*i +: 10];
        r_y[i] <= INIT_Y[9*i +: 9];
      end
    end else begin
      r_vs_d1     <= iVS;
      r_vs_d2     <= r_vs_d1;
      if (w_frame_evt && enable)
        r_frame_cnt <= (r_frame_cnt == LP_DIV_LAST) ? 8'd0 : r_frame_cnt + 8'd1;
      r_move_tick <= w_tick_now;
      r_collide   <= w_tick_now & w_collide;
      r_bgr       <= w_bgr;
      r_hit       <= w_hit;
      if (w_tick_now) begin
        r_dx <= w_ndx;
        r_dy <= w_ndy;
        for (int i = 0; i < NUM_OBJ; i++) begin
          r_x[i] <= w_nx[i];
          r_y[i] <= w_ny[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_pos
    assign obj_x[10*g +: 10] = r_x[g];
    assign obj_y[9*g +: 9]   = r_y[g];
  end

  assign oBGR      = r_bgr;
  assign oHIT      = r_hit;
  assign move_tick = r_move_tick;
  assign collide   = r_collide;

endmodule

// File: tb/tb_pong_sprite_engine.sv
// Directed bench: one engine with a 3-frame tick and a ball near the right wall,
// a second with a paddle at the top edge overlapping a ball.
module tb_pong_sprite_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] bg;

  logic        vs1, blank1, en1;
  logic [9:0]  px1;
  logic [8:0]  py1;
  logic [7:0]  btn1;
  logic [23:0] bgr1;
  logic [1:0]  hit1;
  logic [19:0] ox1;
  logic [17:0] oy1;
  logic        tick1, col1;

  logic        vs2, blank2, en2;
  logic [9:0]  px2;
  logic [8:0]  py2;
  logic [7:0]  btn2;
  logic [23:0] bgr2;
  logic [1:0]  hit2;
  logic [19:0] ox2;
  logic [17:0] oy2;
  logic        tick2, col2;

  pong_sprite_engine #(
    .FRAME_DIV (3),
    .INIT_X    ({10'd607, 10'd100}),
    .INIT_Y    ({9'd200, 9'd100})
  ) dut1 (
    .iVGA_CLK (clk), .reset (rst), .iVS (vs1), .iBLANK_n (blank1),
    .pixel_x (px1), .pixel_y (py1), .bg_bgr (bg), .btn_n (btn1), .enable (en1),
    .oBGR (bgr1), .oHIT (hit1), .obj_x (ox1), .obj_y (oy1),
    .move_tick (tick1), .collide (col1)
  );

  pong_sprite_engine #(
    .FRAME_DIV (1),
    .INIT_X    ({10'd120, 10'd100}),
    .INIT_Y    ({9'd10, 9'd1})
  ) dut2 (
    .iVGA_CLK (clk), .reset (rst), .iVS (vs2), .iBLANK_n (blank2),
    .pixel_x (px2), .pixel_y (py2), .bg_bgr (bg), .btn_n (btn2), .enable (en2),
    .oBGR (bgr2), .oHIT (hit2), .obj_x (ox2), .obj_y (oy2),
    .move_tick (tick2), .collide (col2)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ticks1   = 0;
  int   ticks2   = 0;
  logic last_col1 = 1'b0;
  logic last_col2 = 1'b0;

  always @(negedge clk) begin
    if (tick1 === 1'b1) begin
      ticks1    = ticks1 + 1;
      last_col1 = col1;
    end
    if (tick2 === 1'b1) begin
      ticks2    = ticks2 + 1;
      last_col2 = col2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frame1();
    vs1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 vs1 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic frame2();
    vs2 = 1'b0;
    repeat (4) @(posedge clk);
    #1 vs2 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic pix1(input logic [9:0] x, input logic [8:0] y, input logic b);
    px1 = x; py1 = y; blank1 = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pix2(input logic [9:0] x, input logic [8:0] y, input logic b);
    px2 = x; py2 = y; blank2 = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp_t[6];
    exp_t = '{0, 0, 1, 1, 1, 2};
    rst = 1'b1; bg = 24'h123456;
    vs1 = 1'b1; blank1 = 1'b1; en1 = 1'b1; px1 = '0; py1 = '0; btn1 = 8'hFF;
    vs2 = 1'b1; blank2 = 1'b1; en2 = 1'b1; px2 = '0; py2 = '0; btn2 = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x1",   ox1,   {12'd0, 10'd607, 10'd100});
    check("rst_y1",   oy1,   {14'd0, 9'd200, 9'd100});
    check("rst_bgr1", bgr1,  32'h0);
    check("rst_hit1", hit1,  32'h0);
    check("rst_tick", tick1, 32'h0);
    check("rst_col",  col1,  32'h0);
    check("rst_x2",   ox2,   {12'd0, 10'd120, 10'd100});
    @(posedge clk);
    #1 rst = 1'b0;

    // Rendering around sprite 0 at (100,100)
    pix1(10'd100, 9'd100, 1'b1);
    check("pix_in_bgr",  bgr1, 32'h0000FF);
    check("pix_in_hit",  hit1, 32'h1);
    pix1(10'd132, 9'd100, 1'b1);
    check("pix_right_bgr", bgr1, 32'h123456);
    check("pix_right_hit", hit1, 32'h0);
    pix1(10'd131, 9'd131, 1'b1);
    check("pix_corner_hit", hit1, 32'h1);
    pix1(10'd99, 9'd100, 1'b1);
    check("pix_left_hit", hit1, 32'h0);
    pix1(10'd100, 9'd100, 1'b0);
    check("pix_blank_bgr", bgr1, 32'h0);
    check("pix_blank_hit", hit1, 32'h1);
    blank1 = 1'b1;

    // Frame divider of 3 and ball reversing on the right wall
    for (int k = 0; k < 6; k++) begin
      frame1();
      check($sformatf("ticks_after_frame%0d", k + 1), ticks1, exp_t[k]);
      if (k == 2) begin
        check("ball_wall_x", ox1[19:10], 32'd608);
        check("ball_wall_y", oy1[17:9],  32'd202);
      end
    end
    check("ball_back_x",   ox1[19:10], 32'd606);
    check("ball_back_y",   oy1[17:9],  32'd204);
    check("paddle_still",  ox1[9:0],   32'd100);
    check("no_collide",    last_col1,  32'h0);

    en1 = 1'b0;
    repeat (3) frame1();
    check("frozen_ticks", ticks1,     32'd2);
    check("frozen_x",     ox1[19:10], 32'd606);
    en1 = 1'b1;

    // Paddle clamps at the top while overlapping the ball
    btn2 = 8'b1111_1110;
    frame2();
    check("pad_clamp_y",   oy2[8:0],   32'd0);
    check("pad_x",         ox2[9:0],   32'd100);
    check("col_ball_x",    ox2[19:10], 32'd118);
    check("col_ball_y",    oy2[17:9],  32'd12);
    check("col_pulse",     last_col2,  32'h1);
    check("ticks2_one",    ticks2,     32'd1);
    frame2();
    check("pad_stay_0",    oy2[8:0],   32'd0);
    check("col2_ball_x",   ox2[19:10], 32'd120);
    btn2 = 8'b1111_1101;
    frame2();
    check("pad_down",      oy2[8:0],   32'd2);
    btn2 = 8'b1111_1100;
    frame2();
    check("pad_updown",    oy2[8:0],   32'd2);
    check("ball4_x",       ox2[19:10], 32'd120);
    check("ball4_y",       oy2[17:9],  32'd18);

    // Overlapping sprites: lowest index wins the colour
    pix2(10'd125, 9'd20, 1'b1);
    check("both_bgr", bgr2, 32'h0000FF);
    check("both_hit", hit2, 32'h3);
    pix2(10'd140, 9'd40, 1'b1);
    check("ball_bgr", bgr2, 32'h00FF00);
    check("ball_hit", hit2, 32'h2);
    pix2(10'd125, 9'd20, 1'b0);
    check("both_blank_bgr", bgr2, 32'h0);
    check("both_blank_hit", hit2, 32'h3);

    // Reset mid-count restarts the frame divider
    repeat (2) frame1();
    rst = 1'b1;
    @(negedge clk);
    check("rerst_x", ox1[19:10], 32'd607);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) frame1();
    check("rerst_no_tick", ticks1, 32'd2);
    frame1();
    check("rerst_tick",    ticks1, 32'd3);
    check("rerst_ball_x",  ox1[19:10], 32'd608);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
